alu_responder: RTL

- Responder end of the control-unit ALU handshake. Accepts a request (`ALUenable` plus the 37-bit one-hot decoded instruction bus and operands), computes the RV32I result, and returns it on `ALUoutput` with `ALUready`.
- Registered, FSM-controlled. Sits between the decoder/register file and the control unit in the 4-phase core.

---
 rtl/alu_responder_pkg.sv | 78 +++++++
 rtl/alu_shifter.sv | 91 +++++++++
 rtl/alu_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_responder_pkg.sv
// ---------------------------------------------------------------------------
// rv32_instr_pkg
// Shared constants for the RV32I ALU responder:
//   - bit positions of the one-hot decoded instruction bus (I_ADD .. I_AUIPC)
//   - IBUS_W, width of that bus
//   - base RV32I major opcodes, for the decoder side of the codebase
//   - ALU responder FSM state encoding
//   - helper classifying shift operations
// ---------------------------------------------------------------------------
package rv32_instr_pkg;

  localparam int IBUS_W = 37;

  // R-type
  localparam int I_ADD   = 0;
  localparam int I_SUB   = 1;
  localparam int I_SLL   = 2;
  localparam int I_SLT   = 3;
  localparam int I_SLTU  = 4;
  localparam int I_XOR   = 5;
  localparam int I_SRL   = 6;
  localparam int I_SRA   = 7;
  localparam int I_OR    = 8;
  localparam int I_AND   = 9;
  // I-type arithmetic
  localparam int I_ADDI  = 10;
  localparam int I_SLTI  = 11;
  localparam int I_SLTIU = 12;
  localparam int I_XORI  = 13;
  localparam int I_ORI   = 14;
  localparam int I_ANDI  = 15;
  localparam int I_SLLI  = 16;
  localparam int I_SRLI  = 17;
  localparam int I_SRAI  = 18;
  // Loads / stores
  localparam int I_LB    = 19;
  localparam int I_LH    = 20;
  localparam int I_LW    = 21;
  localparam int I_LBU   = 22;
  localparam int I_LHU   = 23;
  localparam int I_SB    = 24;
  localparam int I_SH    = 25;
  localparam int I_SW    = 26;
  // Branches
  localparam int I_BEQ   = 27;
  localparam int I_BNE   = 28;
  localparam int I_BLT   = 29;
  localparam int I_BGE   = 30;
  localparam int I_BLTU  = 31;
  localparam int I_BGEU  = 32;
  // Jumps / upper immediates
  localparam int I_JAL   = 33;
  localparam int I_JALR  = 34;
  localparam int I_LUI   = 35;
  localparam int I_AUIPC = 36;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic is_shift_op(input int idx);
    return (idx == I_SLL)  || (idx == I_SRL)  || (idx == I_SRA) ||
           (idx == I_SLLI) || (idx == I_SRLI) || (idx == I_SRAI);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
// Shift unit for the ALU responder.
//   Default build : combinational barrel shifter, done mirrors start.
//   SERIAL_SHIFT_EN defined : loads value/shamt on start and shifts one bit
//   per cycle. result is the value after the *next* shift step while busy, so
//   the owner can register the final value on the same edge that done is
//   seen. When idle, result passes value straight through (shamt=0 case).
// Ports:
//   clk, rst      (serial build only) clock, async active-high reset
//   start         operation accepted this cycle
//   dir           0 = left, 1 = right
//   arith         right shift fills with the sign bit
//   shamt         shift amount
//   value         operand to shift
//   result        shifted value (see above for serial semantics)
//   done          final step completes at the next rising edge
// ---------------------------------------------------------------------------
module alu_shifter #(
  parameter int XLEN = 32
) (
`ifdef SERIAL_SHIFT_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic            start,
  input  logic            dir,
  input  logic            arith,
  input  logic [4:0]      shamt,
  input  logic [XLEN-1:0] value,
  output logic [XLEN-1:0] result,
  output logic            done
);

`ifdef SERIAL_SHIFT_EN
  logic            active_reg;
  logic [4:0]      count_reg;
  logic [XLEN-1:0] val_reg;
  logic            dir_reg;
  logic            arith_reg;
  logic [XLEN-1:0] step_val;

  always_comb begin
    if (dir_reg) begin
      step_val = {arith_reg & val_reg[XLEN-1], val_reg[XLEN-1:1]};
    end else begin
      step_val = {val_reg[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg <= 1'b0;
      count_reg  <= '0;
      val_reg    <= '0;
      dir_reg    <= 1'b0;
      arith_reg  <= 1'b0;
    end else if (active_reg) begin
      val_reg   <= step_val;
      count_reg <= count_reg - 5'd1;
      if (count_reg == 5'd1) begin
        active_reg <= 1'b0;
      end
    end else if (start && (shamt != 5'd0)) begin
      active_reg <= 1'b1;
      count_reg  <= shamt;
      val_reg    <= value;
      dir_reg    <= dir;
      arith_reg  <= arith;
    end
  end

  assign result = active_reg ? step_val : value;
  assign done   = active_reg && (count_reg == 5'd1);
`else
  always_comb begin
    if (dir) begin
      if (arith) begin
        result = XLEN'($signed(value) >>> shamt);
      end else begin
        result = value >> shamt;
      end
    end else begin
      result = value << shamt;
    end
  end

  assign done = start;
`endif

endmodule

// File: rtl/alu_responder.sv
// ---------------------------------------------------------------------------
// alu_responder
// Responder end of the control-unit ALU handshake. A request (ALUenable with
// the one-hot decoded instruction and operands) is accepted in IDLE, the
// RV32I result is registered on ALUoutput and ALUready is raised one cycle
// later. ALUready stays high in DONE until ALUenable is sampled low.
// Optional macro SERIAL_SHIFT_EN: shift ops run one bit per cycle through
// EXEC with ALUbusy high; otherwise shifts are single-cycle.
// Ports:
//   clk, rst          clock (rising), async active-high reset
//   ALUenable         request valid
//   ALU_instr_bus     one-hot decoded instruction (lowest set bit wins)
//   rs1_value         operand 1
//   rs2_value         operand 2
//   imm               sign-extended immediate
//   pc                PC of the instruction
//   ALUoutput         registered result
//   ALUready          result valid (level)
//   ALUbusy           accepted, result not yet ready
// ---------------------------------------------------------------------------
module alu_responder #(
  parameter int XLEN   = 32,
  parameter int IBUS_W = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ALUenable,
  input  logic [IBUS_W-1:0] ALU_instr_bus,
  input  logic [XLEN-1:0]   rs1_value,
  input  logic [XLEN-1:0]   rs2_value,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   ALUoutput,
  output logic              ALUready,
  output logic              ALUbusy
);
  import rv32_instr_pkg::*;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] out_reg, out_next;
  logic            ready_reg, ready_next;
  logic            busy_reg, busy_next;

  int              sel_idx;
  logic            sel_shift;
  logic            sh_start, sh_dir, sh_arith, sh_done, go_exec;
  logic [4:0]      sh_amt;
  logic [XLEN-1:0] sh_result, calc_result;

  // Priority decode: scanning downward leaves the lowest set index.
  // An empty bus leaves an out-of-range index, which decodes to 0.
  always_comb begin
    sel_idx = IBUS_W;
    for (int i = IBUS_W - 1; i >= 0; i--) begin
      if (ALU_instr_bus[i]) begin
        sel_idx = i;
      end
    end
  end

  assign sel_shift = is_shift_op(sel_idx);
  assign sh_dir    = (sel_idx == I_SRL) || (sel_idx == I_SRA) ||
                     (sel_idx == I_SRLI) || (sel_idx == I_SRAI);
  assign sh_arith  = (sel_idx == I_SRA) || (sel_idx == I_SRAI);
  assign sh_amt    = ((sel_idx == I_SLLI) || (sel_idx == I_SRLI) ||
                      (sel_idx == I_SRAI)) ? imm[4:0] : rs2_value[4:0];
  assign sh_start  = (state_reg == ST_IDLE) && ALUenable && sel_shift;

`ifdef SERIAL_SHIFT_EN
  assign go_exec = sh_start && (sh_amt != 5'd0);
`else
  assign go_exec = 1'b0;
`endif

  alu_shifter #(.XLEN(XLEN)) u_shifter (
`ifdef SERIAL_SHIFT_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .start  (sh_start),
    .dir    (sh_dir),
    .arith  (sh_arith),
    .shamt  (sh_amt),
    .value  (rs1_value),
    .result (sh_result),
    .done   (sh_done)
  );

  always_comb begin
    calc_result = '0;
    case (sel_idx)
      I_ADD:                       calc_result = rs1_value + rs2_value;
      I_SUB:                       calc_result = rs1_value - rs2_value;
      I_SLT:                       calc_result = XLEN'($signed(rs1_value) < $signed(rs2_value));
      I_SLTU:                      calc_result = XLEN'(rs1_value < rs2_value);
      I_XOR:                       calc_result = rs1_value ^ rs2_value;
      I_OR:                        calc_result = rs1_value | rs2_value;
      I_AND:                       calc_result = rs1_value & rs2_value;
      I_SLL, I_SRL, I_SRA,
      I_SLLI, I_SRLI, I_SRAI:      calc_result = sh_result;
      I_ADDI:                      calc_result = rs1_value + imm;
      I_SLTI:                      calc_result = XLEN'($signed(rs1_value) < $signed(imm));
      I_SLTIU:                     calc_result = XLEN'(rs1_value < imm);
      I_XORI:                      calc_result = rs1_value ^ imm;
      I_ORI:                       calc_result = rs1_value | imm;
      I_ANDI:                      calc_result = rs1_value & imm;
      I_LB, I_LH, I_LW, I_LBU, I_LHU,
      I_SB, I_SH, I_SW:            calc_result = rs1_value + imm;
      I_BEQ:                       calc_result = XLEN'(rs1_value == rs2_value);
      I_BNE:                       calc_result = XLEN'(rs1_value != rs2_value);
      I_BLT:                       calc_result = XLEN'($signed(rs1_value) < $signed(rs2_value));
      I_BGE:                       calc_result = XLEN'($signed(rs1_value) >= $signed(rs2_value));
      I_BLTU:                      calc_result = XLEN'(rs1_value < rs2_value);
      I_BGEU:                      calc_result = XLEN'(rs1_value >= rs2_value);
      I_JAL, I_JALR:               calc_result = pc + XLEN'(4);
      I_LUI:                       calc_result = imm;
      I_AUIPC:                     calc_result = pc + imm;
      default:                     calc_result = '0;
    endcase
  end

  // Operands are consumed on the accepting edge (result or shifter load),
  // so later input changes cannot disturb the held result.
  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ALUenable) begin
          if (go_exec) begin
            state_next = ST_EXEC;
            busy_next  = 1'b1;
            ready_next = 1'b0;
          end else begin
            state_next = ST_DONE;
            out_next   = calc_result;
            ready_next = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // Runs to completion regardless of ALUenable.
        if (sh_done) begin
          state_next = ST_DONE;
          out_next   = sh_result;
          busy_next  = 1'b0;
          ready_next = 1'b1;
        end
      end
      ST_DONE: begin
        if (!ALUenable) begin
          state_next = ST_IDLE;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ready_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      out_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  assign ALUoutput = out_reg;
  assign ALUready  = ready_reg;
  assign ALUbusy   = busy_reg;

endmodule
